instr_loader: RTL and testbench



---
 rtl/instr_loader.sv | 115 +++++++++++
 tb/tb_instr_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Front end for the bit-serial core. It synchronises and debounces the push-button,
// then assembles a 16-bit instruction from two switch bytes, one byte per press.
`timescale 1ns/1ps
module instr_loader #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  sw_in,
    input  logic        btn_raw,
    input  logic        core_busy,
    output logic [3:0]  opcode,
    output logic [11:0] instr,
    output logic        inst_done,
    output logic        btn_edge,
    output logic        byte_sel,
    output logic        drop
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {S_HI, S_LO} state_t;

    logic          r_s1;
    logic          r_s2;
    logic          r_level;
    logic [CW-1:0] r_dbc_cnt;
    logic          r_btn_edge;

    state_t        r_state;
    logic [7:0]    r_hold_hi;
    logic [3:0]    r_opcode;
    logic [11:0]   r_instr;
    logic          r_inst_done;
    logic          r_drop;

    logic          w_differ;
    logic          w_flip;

    assign w_differ = (r_s2 != r_level);
    assign w_flip   = w_differ && (r_dbc_cnt == CNT_LAST);

    // NOTE: non-blocking assignments keep btn_raw -> s1 -> s2 a genuine two-flop chain.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= btn_raw;
            r_s2 <= r_s1;
        end
    end

    // The edge pulse is registered alongside the level, so it rises in the first cycle the level reads 1.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_level    <= 1'b0;
            r_dbc_cnt  <= '0;
            r_btn_edge <= 1'b0;
        end else begin
            r_btn_edge <= w_flip && !r_level;
            if (!w_differ) begin
                r_dbc_cnt <= '0;
            end else if (w_flip) begin
                r_level   <= ~r_level;
                r_dbc_cnt <= '0;
            end else begin
                r_dbc_cnt <= r_dbc_cnt + CW'(1);
            end
        end
    end

    // A press seen while the core is busy is refused. The state and both bytes stay untouched.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= S_HI;
            r_hold_hi   <= 8'h00;
            r_opcode    <= 4'h0;
            r_instr     <= 12'h000;
            r_inst_done <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_inst_done <= 1'b0;
            r_drop      <= 1'b0;
            if (r_btn_edge) begin
                if (core_busy) begin
                    r_drop <= 1'b1;
                end else begin
                    case (r_state)
                        S_HI: begin
                            r_hold_hi <= sw_in;
                            r_state   <= S_LO;
                        end
                        S_LO: begin
                            r_opcode    <= r_hold_hi[7:4];
                            r_instr     <= {r_hold_hi[3:0], sw_in};
                            r_inst_done <= 1'b1;
                            r_state     <= S_HI;
                        end
                        default: r_state <= S_HI;
                    endcase
                end
            end
        end
    end

    assign opcode    = r_opcode;
    assign instr     = r_instr;
    assign inst_done = r_inst_done;
    assign btn_edge  = r_btn_edge;
    assign byte_sel  = (r_state == S_LO);
    assign drop      = r_drop;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader with DEBOUNCE_CYCLES=4. The stimulus pushes expected
// {opcode, instr} words, and a negedge monitor pops them on every inst_done.
`timescale 1ns/1ps
module tb_instr_loader;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  sw_in = 8'h00;
    logic        btn_raw = 1'b0;
    logic        core_busy = 1'b0;
    logic [3:0]  opcode;
    logic [11:0] instr;
    logic        inst_done;
    logic        btn_edge;
    logic        byte_sel;
    logic        drop;

    int checks = 0;
    int failures = 0;
    int n_edge = 0;
    int n_done = 0;
    int n_drop = 0;

    logic [15:0] exp_q[$];
    logic [3:0]  m_op = 4'h0;
    logic [11:0] m_ins = 12'h000;
    logic        prev_done = 1'b0;
    logic        prev_drop = 1'b0;

    instr_loader #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .sw_in     (sw_in),
        .btn_raw   (btn_raw),
        .core_busy (core_busy),
        .opcode    (opcode),
        .instr     (instr),
        .inst_done (inst_done),
        .btn_edge  (btn_edge),
        .byte_sel  (byte_sel),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    // The monitor tracks the last completed instruction. Outputs must match it in every cycle outside reset.
    always @(negedge clk) begin
        if (rstn) begin
            if (btn_edge) n_edge++;
            if (drop) n_drop++;
            if (inst_done || drop) begin
                checks++;
                if ((inst_done && drop) || (inst_done && prev_done) || (drop && prev_drop)) begin
                    failures++;
                    $display("FAIL strobe_excl: inst_done=%0b drop=%0b prev_done=%0b prev_drop=%0b",
                             inst_done, drop, prev_done, prev_drop);
                end
            end
            if (inst_done) begin
                n_done++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: got %h/%h, no instruction expected", opcode, instr);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if ({opcode, instr} !== e) begin
                        failures++;
                        $display("FAIL sb_value: got %h/%h expected %h/%h", opcode, instr, e[15:12], e[11:0]);
                    end
                    m_op  = e[15:12];
                    m_ins = e[11:0];
                end
            end else begin
                checks++;
                if (opcode !== m_op || instr !== m_ins) begin
                    failures++;
                    $display("FAIL out_stable: got %h/%h expected %h/%h", opcode, instr, m_op, m_ins);
                end
            end
            prev_done = inst_done;
            prev_drop = drop;
        end else begin
            prev_done = 1'b0;
            prev_drop = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset(input int cycles);
        @(posedge clk);
        #1 rstn = 1'b0;
        btn_raw = 1'b0;
        core_busy = 1'b0;
        m_op = 4'h0;
        m_ins = 12'h000;
        repeat (cycles) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    // A clean press: hold well past qualification, then release. Switches change after the hold.
    task automatic press(input logic [7:0] b, input logic busy);
        @(posedge clk);
        #1 sw_in = b;
        core_busy = busy;
        btn_raw = 1'b1;
        repeat (D + 8) @(posedge clk);
        #1 btn_raw = 1'b0;
        sw_in = ~b;
        repeat (D + 8) @(posedge clk);
        #1 core_busy = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_out(input string name, input logic [3:0] op, input logic [11:0] ins,
                              input logic bs);
        checks++;
        if (opcode !== op || instr !== ins || byte_sel !== bs) begin
            failures++;
            $display("FAIL %s: got op=%h instr=%h byte_sel=%0b expected op=%h instr=%h byte_sel=%0b",
                     name, opcode, instr, byte_sel, op, ins, bs);
        end
    endtask

    task automatic test_reset;
        apply_reset(3);
        @(negedge clk);
        checks++;
        if ({opcode, instr, inst_done, btn_edge, byte_sel, drop} !== 20'h0) begin
            failures++;
            $display("FAIL reset_outputs: got op=%h instr=%h done=%0b edge=%0b sel=%0b drop=%0b expected all zero",
                     opcode, instr, inst_done, btn_edge, byte_sel, drop);
        end
    endtask

    task automatic test_edge_timing;
        int e0;
        e0 = n_edge;
        @(posedge clk);
        #1 btn_raw = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (btn_edge !== (e == D + 2)) begin
                failures++;
                $display("FAIL edge_timing: edge %0d after first sample btn_edge=%0b expected %0b",
                         e, btn_edge, (e == D + 2));
            end
        end
        #1 btn_raw = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            checks++;
            if (btn_edge !== 1'b0) begin
                failures++;
                $display("FAIL edge_release: cycle %0d btn_edge=%0b expected 0", e, btn_edge);
            end
        end
        checks++;
        if (n_edge - e0 != 1) begin
            failures++;
            $display("FAIL edge_count: got %0d pulses expected 1", n_edge - e0);
        end
    endtask

    task automatic test_glitch;
        int e0;
        e0 = n_edge;
        @(posedge clk);
        #1 btn_raw = 1'b1;
        repeat (3) @(posedge clk);
        #1 btn_raw = 1'b0;
        @(posedge clk);
        #1 btn_raw = 1'b1;
        repeat (3) @(posedge clk);
        #1 btn_raw = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        checks++;
        if (n_edge != e0 || dut.r_level !== 1'b0 || dut.r_dbc_cnt !== '0) begin
            failures++;
            $display("FAIL glitch: pulses=%0d level=%0b cnt=%0d expected 0/0/0",
                     n_edge - e0, dut.r_level, dut.r_dbc_cnt);
        end
    endtask

    task automatic test_basic;
        int d0;
        d0 = n_done;
        expect_out("basic_start", 4'h0, 12'h000, 1'b0);
        press(8'h3A, 1'b0);
        expect_out("basic_after_hi", 4'h0, 12'h000, 1'b1);
        exp_q.push_back(16'h3A5C);
        press(8'h5C, 1'b0);
        expect_out("basic_done", 4'h3, 12'hA5C, 1'b0);
        checks++;
        if (n_done - d0 != 1) begin
            failures++;
            $display("FAIL basic_done_count: got %0d expected 1", n_done - d0);
        end
    endtask

    task automatic test_busy_drop;
        int p0;
        int d0;
        p0 = n_drop;
        d0 = n_done;
        press(8'h11, 1'b1);
        expect_out("busy_refused", 4'h3, 12'hA5C, 1'b0);
        checks++;
        if (n_drop - p0 != 1 || n_done != d0) begin
            failures++;
            $display("FAIL busy_drop: drops=%0d dones=%0d expected 1/0", n_drop - p0, n_done - d0);
        end
        exp_q.push_back(16'h7201);
        press(8'h72, 1'b0);
        press(8'h01, 1'b0);
        expect_out("busy_after", 4'h7, 12'h201, 1'b0);
    endtask

    task automatic test_reset_mid_entry;
        press(8'hF0, 1'b0);
        expect_out("mid_hi_taken", 4'h7, 12'h201, 1'b1);
        apply_reset(1);
        @(negedge clk);
        expect_out("mid_reset", 4'h0, 12'h000, 1'b0);
        checks++;
        if (dut.r_hold_hi !== 8'h00) begin
            failures++;
            $display("FAIL mid_hold: got %h expected 00", dut.r_hold_hi);
        end
        exp_q.push_back(16'h1234);
        press(8'h12, 1'b0);
        press(8'h34, 1'b0);
        expect_out("mid_after", 4'h1, 12'h234, 1'b0);
    endtask

    task automatic test_back_to_back;
        int d0;
        d0 = n_done;
        exp_q.push_back(16'h9ABC);
        press(8'h9A, 1'b0);
        press(8'hBC, 1'b0);
        expect_out("b2b_first", 4'h9, 12'hABC, 1'b0);
        exp_q.push_back(16'h0123);
        press(8'h01, 1'b0);
        expect_out("b2b_hold", 4'h9, 12'hABC, 1'b1);
        press(8'h23, 1'b0);
        expect_out("b2b_second", 4'h0, 12'h123, 1'b0);
        checks++;
        if (n_done - d0 != 2) begin
            failures++;
            $display("FAIL b2b_done_count: got %0d expected 2", n_done - d0);
        end
    endtask

    initial begin
        test_reset();
        test_edge_timing();
        test_reset();
        test_glitch();
        test_basic();
        test_busy_drop();
        test_reset_mid_entry();
        test_back_to_back();
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d instructions never completed", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
